ssd_capture: RTL
================

# ssd_capture

Seven-segment capture receiver: the inverse of the team's BCD-to-seven-segment decoder. Samples a multiplexed display bus (7 segment lines plus one-hot digit strobes), filters glitches, decodes each stable segment pattern back to a BCD nibble, and assembles a full frame of NUM_DIG digits. Sits on the observation side of the display path; used for loopback self-check and for reading external 7-segment panels.

## Interface

- STABLE_CYC, 4, sampled cycles a (seg_in, dig_sel) pair must hold before capture; legal range 1..15.
- NUM_DIG, 4, number of multiplexed digits; legal range 1..8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: asynchronous, active-low.
- seg_in  input  7  segment pattern, bit-for-bit the decoder's output encoding.
- dig_sel  input  NUM_DIG  digit strobe, active-high, one-hot when valid; bit k selects digit k.
- bcd_out  output  4*NUM_DIG  last complete frame; nibble k = digit k (digit NUM_DIG-1 in MS nibble).
- frame_valid  output  1  one-cycle pulse when bcd_out updates.
- digit_err  output  NUM_DIG  per-digit invalid-pattern flags of the last complete frame.

## Operation

- Decode map (seg_in -> nibble): 0111111->0, 0110000->1, 1011011->2, 1111001->3, 1110100->4, 1101101->5, 1100111->6, 0111000->7, 1111111->8, 1111100->9. Any other pattern -> nibble 4'hF, error bit set for that digit.
- Input stage: seg_in and dig_sel registered every edge into s_q. Stability counter cnt (4 bits, saturating at 15): cleared when incoming {seg_in, dig_sel} differs from s_q, else incremented.
- FSM, one state register:
  - IDLE: s_q.dig_sel zero or multi-hot (blanking/overlap); nothing captured. Go WAIT when s_q.dig_sel is one-hot.
  - WAIT: one-hot digit present, cnt counting. Any input change -> stay WAIT with cnt=0 (or IDLE if new dig_sel not one-hot). When cnt == STABLE_CYC-1 and input still unchanged: write slot k (decoded nibble + error bit), set seen[k], go CAPTURED.
  - CAPTURED: no further writes while input unchanged. Any change -> WAIT or IDLE as above.
- Working buffer: slot[NUM_DIG], err[NUM_DIG], seen mask. Re-capture of a digit already seen in this frame overwrites it (latest wins). Digit order is free.
- Frame completion: on the edge a capture makes seen all-ones, slots copy to bcd_out/digit_err at the following edge, frame_valid pulses for that one cycle, and seen clears. Slot contents are retained; only seen clears.
- Capture that completes a frame and a new capture for the next frame cannot coincide (each capture needs at least STABLE_CYC+1 edges); no arbitration needed.
- Reset (any time, including mid-frame): FSM IDLE, cnt 0, s_q 0, seen 0, slots 0, partial frame discarded.

## Timing

- Reset values: bcd_out = 0, digit_err = 0, frame_valid = 0.
- Let E0 be the first edge sampling a new one-hot (seg_in, dig_sel). With inputs unchanged, the slot is written at edge E0+STABLE_CYC. Minimum strobe width STABLE_CYC+1 cycles; shorter strobes are never captured.
- If that capture completes the frame: bcd_out, digit_err, and frame_valid update at edge E0+STABLE_CYC+1; frame_valid deasserts at the next edge.
- bcd_out/digit_err are stable between frame_valid pulses.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- STABLE_CYC=4, NUM_DIG=4; strobe digits 3,2,1,0 with 1011011, 0111111, 1011011, 1110100, each 6 cycles, 1 blank cycle (dig_sel=0) between -> single frame_valid pulse 5 edges after digit 0 is first sampled; bcd_out=16'h2024, digit_err=4'b0000.
- Glitch: digit 1 shows 1111001 for 3 cycles, then 0110000 for 6 cycles -> nibble 1 = 1, never 3.
- Invalid pattern 0000001 on digit 2, valid digits on the others -> nibble 2 = F, digit_err=4'b0100.
- Two-hot dig_sel=4'b0011 held 10 cycles -> no capture, seen unchanged; frame completes only after proper one-hot strobes.
- Digit 0 captured as 5, then again as 9 before frame completes -> final nibble 0 = 9; exactly one frame_valid.
- rst_n low for 1 cycle after 3 digits captured -> outputs 0 immediately; one further digit produces no frame; a full 4-digit sequence then yields frame_valid.

Source files
------------

// File: rtl/ssd_capture.sv
`default_nettype none
// ssd_capture: debounces a multiplexed 7-segment bus, decodes each digit back to BCD
// and publishes a complete NUM_DIG-digit frame.  Rev 1.0
module ssd_capture #(
   parameter int STABLE_CYC = 4,
   parameter int NUM_DIG    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           seg_in,
   input  logic [NUM_DIG-1:0]   dig_sel,
   output logic [4*NUM_DIG-1:0] bcd_out,
   output logic                 frame_valid,
   output logic [NUM_DIG-1:0]   digit_err
);
   localparam int         SW      = 7 + NUM_DIG;
   localparam logic [3:0] CNT_HIT = 4'(STABLE_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [SW-1:0]            s_q;
   logic [3:0]               cnt_q, cnt_d;
   logic [NUM_DIG-1:0][3:0]  slot_q, slot_d;
   logic [NUM_DIG-1:0]       err_q, err_d;
   logic [NUM_DIG-1:0]       seen_q, seen_d;
   logic                     done_q, done_d;

   logic [SW-1:0]            in_w;
   logic [NUM_DIG-1:0]       dig_q_w;
   logic                     changed_w, onehot_in_w, onehot_q_w, cap_w;
   logic [3:0]               nib_w;
   logic                     bad_w;

   function automatic logic is_onehot(input logic [NUM_DIG-1:0] v);
      return (v != '0) && ((v & (v - NUM_DIG'(1))) == '0);
   endfunction

   assign in_w        = {seg_in, dig_sel};
   assign dig_q_w     = s_q[NUM_DIG-1:0];
   assign changed_w   = (in_w != s_q);
   assign onehot_in_w = is_onehot(dig_sel);
   assign onehot_q_w  = is_onehot(dig_q_w);
   assign cnt_d       = changed_w ? 4'd0 : ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1);

   always_comb begin
      nib_w = 4'hF;
      bad_w = 1'b0;
      case (s_q[SW-1:NUM_DIG])
         7'b0111111: nib_w = 4'd0;
         7'b0110000: nib_w = 4'd1;
         7'b1011011: nib_w = 4'd2;
         7'b1111001: nib_w = 4'd3;
         7'b1110100: nib_w = 4'd4;
         7'b1101101: nib_w = 4'd5;
         7'b1100111: nib_w = 4'd6;
         7'b0111000: nib_w = 4'd7;
         7'b1111111: nib_w = 4'd8;
         7'b1111100: nib_w = 4'd9;
         default:    bad_w = 1'b1;
      endcase
   end

   // A changed input always restarts qualification; only an unchanged one-hot strobe can capture.
   always_comb begin
      state_d = state_q;
      cap_w   = 1'b0;
      if (changed_w) begin
         state_d = onehot_in_w ? ST_WAIT : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_WAIT: begin
               if (!onehot_q_w) begin
                  state_d = ST_IDLE;
               end else if (cnt_q == CNT_HIT) begin
                  cap_w   = 1'b1;
                  state_d = ST_CAPT;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_CAPT: state_d = ST_CAPT;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      slot_d = slot_q;
      err_d  = err_q;
      seen_d = seen_q;
      done_d = 1'b0;
      if (done_q) seen_d = '0;
      if (cap_w) begin
         for (int k = 0; k < NUM_DIG; k++) begin
            if (dig_q_w[k]) begin
               slot_d[k] = nib_w;
               err_d[k]  = bad_w;
            end
         end
         seen_d = seen_q | dig_q_w;
         done_d = &(seen_q | dig_q_w);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         cnt_q       <= 4'd0;
         slot_q      <= '0;
         err_q       <= '0;
         seen_q      <= '0;
         done_q      <= 1'b0;
         bcd_out     <= '0;
         digit_err   <= '0;
         frame_valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= in_w;
         cnt_q       <= cnt_d;
         slot_q      <= slot_d;
         err_q       <= err_d;
         seen_q      <= seen_d;
         done_q      <= done_d;
         frame_valid <= done_q;
         if (done_q) begin
            bcd_out   <= slot_q;
            digit_err <= err_q;
         end
      end
   end
endmodule
`default_nettype wire
